// File: rtl/char_console_writer.sv
// char_console_writer: turns an ASCII byte stream into character RAM
// writes, tracking a row/column cursor and clearing lines and screen.
module char_console_writer #(
   parameter int         COLS  = 80,
   parameter int         ROWS  = 25,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  char_data,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [10:0] write_character_pos,
   output logic [7:0]  write_character,
   output logic        write_strobe,
   output logic [10:0] cursor_pos,
   output logic        busy
);

   localparam logic [10:0] NCOLS    = 11'(COLS);
   localparam logic [10:0] LAST_COL = 11'(COLS - 1);
   localparam logic [10:0] LAST_ROW = 11'(ROWS - 1);
   localparam logic [10:0] LAST_ALL = 11'(COLS * ROWS - 1);

   typedef enum logic [1:0] {
      S_CLEAR_ALL,
      S_IDLE,
      S_CLEAR_LINE
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [10:0] col_q, col_d;
   logic [10:0] row_q, row_d;
   logic [10:0] base_q, base_d;
   logic [10:0] pos_q, pos_d;
   logic [7:0]  data_q, data_d;
   logic        strobe_q, strobe_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;

   logic        take;
   logic        is_print, is_lf, is_cr, is_bs, is_ff;
   logic [10:0] nrow, nbase;

   assign take     = char_valid & ready_q;
   assign is_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
   assign is_lf    = (char_data == 8'h0A);
   assign is_cr    = (char_data == 8'h0D);
   assign is_bs    = (char_data == 8'h08);
   assign is_ff    = (char_data == 8'h0C);

   // Next row and its base address; no scroll, the bottom row wraps to the top.
   always_comb begin
      nrow  = row_q + 11'd1;
      nbase = base_q + NCOLS;
      if (row_q == LAST_ROW) begin
         nrow  = '0;
         nbase = '0;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      col_d    = col_q;
      row_d    = row_q;
      base_d   = base_q;
      pos_d    = pos_q;
      data_d   = data_q;
      strobe_d = 1'b0;

      unique case (state_q)
         S_CLEAR_ALL: begin
            strobe_d = 1'b1;
            pos_d    = base_q + cnt_q;
            data_d   = BLANK;
            if (cnt_q == LAST_ALL) begin
               cnt_d   = '0;
               col_d   = '0;
               row_d   = '0;
               base_d  = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end

         S_CLEAR_LINE: begin
            strobe_d = 1'b1;
            pos_d    = base_q + cnt_q;
            data_d   = BLANK;
            if (cnt_q == LAST_COL) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end

         S_IDLE: begin
            if (take) begin
               unique case (1'b1)
                  is_print: begin
                     strobe_d = 1'b1;
                     pos_d    = base_q + col_q;
                     data_d   = char_data;
                     if (col_q == LAST_COL) begin
                        col_d   = '0;
                        row_d   = nrow;
                        base_d  = nbase;
                        cnt_d   = '0;
                        state_d = S_CLEAR_LINE;
                     end else begin
                        col_d = col_q + 11'd1;
                     end
                  end
                  is_lf: begin
                     col_d   = '0;
                     row_d   = nrow;
                     base_d  = nbase;
                     cnt_d   = '0;
                     state_d = S_CLEAR_LINE;
                  end
                  is_cr: begin
                     col_d = '0;
                  end
                  is_bs: begin
                     if (col_q != '0) begin
                        col_d    = col_q - 11'd1;
                        strobe_d = 1'b1;
                        pos_d    = base_q + col_q - 11'd1;
                        data_d   = BLANK;
                     end
                  end
                  is_ff: begin
                     cnt_d   = '0;
                     col_d   = '0;
                     row_d   = '0;
                     base_d  = '0;
                     state_d = S_CLEAR_ALL;
                  end
                  default: begin
                  end
               endcase
            end
         end

         default: begin
            state_d = S_CLEAR_ALL;
            cnt_d   = '0;
            col_d   = '0;
            row_d   = '0;
            base_d  = '0;
         end
      endcase

      // Ready only once a full cycle has been spent settled in IDLE,
      // so it rises the cycle after the last clear strobe.
      ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
      busy_d  = !ready_d;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= S_CLEAR_ALL;
         cnt_q    <= '0;
         col_q    <= '0;
         row_q    <= '0;
         base_q   <= '0;
         pos_q    <= '0;
         data_q   <= BLANK;
         strobe_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         col_q    <= col_d;
         row_q    <= row_d;
         base_q   <= base_d;
         pos_q    <= pos_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign char_ready          = ready_q;
   assign busy                = busy_q;
   assign write_strobe        = strobe_q;
   assign write_character_pos = pos_q;
   assign write_character     = data_q;
   assign cursor_pos          = base_q + col_q;

endmodule

// File: doc/char_console_writer.md
Name: char_console_writer

Overview:
- Write-side driver for the 2048x8 screen character RAM.
- Accepts an ASCII byte stream over a valid/ready handshake and maintains a row/column cursor.
- Interprets a small set of control codes and emits one-per-cycle write strobes (position, byte) into the RAM's write port.
- Sits between the CPU/UART text source and the character RAM; the VGA scan-out reads the same RAM from the other port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen. COLS*ROWS must be <= 2048.
- BLANK, 8'h20, byte written when clearing.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  synchronous active-low reset.
- char_data  input  8  incoming ASCII byte.
- char_valid  input  1  char_data is valid.
- char_ready  output  1  block can accept a byte this cycle.
- write_character_pos  output  11  RAM write address.
- write_character  output  8  RAM write data.
- write_strobe  output  1  RAM write enable, one write per high cycle.
- cursor_pos  output  11  current cursor linear address, row*COLS+col.
- busy  output  1  high in CLEAR_ALL or CLEAR_LINE.

Behaviour:
- Reset, sampled on a CLK edge with RST_N=0:
  - state=CLEAR_ALL, clear counter=0, row=0, col=0.
  - write_strobe=0, write_character_pos=0, write_character=BLANK.
  - char_ready=0, busy=1, cursor_pos=0.
- Reset mid-operation takes effect at that edge; a partial clear or pending write is abandoned.
- All RAM-side outputs are registered. Accepting a byte at edge N produces its strobe in the cycle after edge N.
- Handshake:
  - A transfer occurs on an edge where char_valid && char_ready.
  - char_ready=1 only in IDLE; it is a registered output.
  - Source holds char_data/char_valid until the transfer. Bytes offered while char_ready=0 are not consumed.
- Address arithmetic:
  - row_base is held in a register and updated by +COLS, or reset to 0 on row wrap. No multiplier.
  - Position = row_base + col, 11 bits. Clear addresses = row_base + counter.
- States:
  - CLEAR_ALL:
    - Writes BLANK to positions 0..COLS*ROWS-1 in ascending order, one per cycle.
    - After the last write: cursor=0, go to IDLE. char_ready rises the cycle after the final strobe.
  - IDLE, on a transfer:
    - Printable 0x20..0x7E:
      - Write byte at cursor, then col+1.
      - If col becomes COLS: col=0, row advances (ROWS-1 wraps to 0), go to CLEAR_LINE for the new row.
    - 0x0A (LF): col=0, row advances with the same wrap, go to CLEAR_LINE.
    - 0x0D (CR): col=0, no write.
    - 0x08 (BS):
      - If col>0: col-1, then write BLANK at the new cursor.
      - If col=0: no write, no move.
    - 0x0C (FF): go to CLEAR_ALL; row, col and counter reset to 0.
    - Any other byte: consumed, no write, no cursor change.
  - CLEAR_LINE:
    - Writes BLANK to row_base..row_base+COLS-1, one per cycle, char_ready=0.
    - Returns to IDLE after COLS writes; cursor stays at the start of the new row.
    - There is no scroll: the screen wraps to the top row and that row is cleared before reuse.
- Outside a write cycle, write_strobe=0. write_character_pos and write_character hold their last values.
- cursor_pos is valid in all states and updates the edge after the transfer.

Test Plan:
- Release RST_N after 3 low cycles:
  - COLS*ROWS=2000 consecutive strobes, pos 0..1999 in order, data 0x20.
  - char_ready=0 throughout, then 1 the next cycle; busy falls at the same time.
- After init, send 'H'(0x48) then 'i'(0x69) back-to-back:
  - Strobes pos 0 data 0x48, then pos 1 data 0x69, on consecutive cycles.
  - cursor_pos=2. Then send 0x07: no strobe, cursor_pos=2.
- Send 80 × 'x' from col 0:
  - Last write at pos 79.
  - Then 80 BLANK strobes at pos 80..159 with char_ready=0, ending with cursor_pos=80.
  - A held char_valid is not consumed until char_ready returns.
- Move cursor to row 24 via 24 LFs, then send LF:
  - Row wraps to 0; BLANK written to pos 0..79; cursor_pos=0.
  - Send CR at col 5 → cursor_pos=0 with no strobe.
- BS handling:
  - Type "abc" at row 0, then BS → strobe pos 2 data 0x20, cursor_pos=2.
  - BS at col 0 → no strobe, cursor unchanged.
  - FF → full 2000-write clear, cursor_pos=0.
- Assert RST_N=0 on the 10th cycle of a CLEAR_LINE:
  - write_strobe=0 and char_ready=0 the next cycle.
  - On release, a full clear restarts from pos 0.
